param_sync_fifo: RTL and testbench

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_mem.sv | 23 ++
 rtl/param_sync_fifo.sv | 113 +++++++++++
 tb/tb_param_sync_fifo.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults and mode constants for the parameterised synchronous FIFO.
package fifo_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int ADDR_W_DEF    = 3;
  localparam int AE_THRESH_DEF = 2;
  localparam int AF_THRESH_DEF = 6;

  // Read-side modes selected by the FWFT parameter
  localparam int FWFT_REGISTERED  = 0;
  localparam int FWFT_FALLTHROUGH = 1;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W storage: synchronous write port, asynchronous read port.
module fifo_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write the addressed word on an accepted write; contents are never reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with occupancy counter, threshold flags, sticky error
// flags and a choice of registered or first-word-fall-through read data.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int AE_THRESH = AE_THRESH_DEF,
  parameter int AF_THRESH = AF_THRESH_DEF,
  parameter int FWFT      = FWFT_REGISTERED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              clr_err,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  output logic [ADDR_W:0]   fifo_counter,
  output logic              empty,
  output logic              full,
  output logic              part_empty,
  output logic              part_full,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_THRESH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_THRESH);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_acc;
  logic              wr_acc;

  assign empty      = (fifo_counter == '0);
  assign full       = (fifo_counter == DEPTH_C);
  assign part_empty = (fifo_counter <= AE_C);
  assign part_full  = (fifo_counter >= AF_C);

  // A read on a full FIFO frees the slot the concurrent write uses
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  fifo_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (in),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  // Pointers and occupancy advance only on accepted transfers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_counter <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + (ADDR_W)'(1);
      if (rd_acc) rd_ptr <= rd_ptr + (ADDR_W)'(1);
      case ({wr_acc, rd_acc})
        2'b10:   fifo_counter <= fifo_counter + (ADDR_W+1)'(1);
        2'b01:   fifo_counter <= fifo_counter - (ADDR_W+1)'(1);
        default: fifo_counter <= fifo_counter;
      endcase
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && !wr_acc) overflow <= 1'b1;
      else if (clr_err)     overflow <= 1'b0;
      if (rd_en && empty)   underflow <= 1'b1;
      else if (clr_err)     underflow <= 1'b0;
    end
  end

  if (FWFT == FWFT_REGISTERED) begin : g_registered
    logic [DATA_W-1:0] out_q;
    logic              valid_q;

    // Capture the head word on each accepted read; valid pulses for one cycle
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        if (rd_acc) out_q <= rd_data;
        valid_q <= rd_acc;
      end
    end

    assign out       = out_q;
    assign out_valid = valid_q;
  end else begin : g_fallthrough
    assign out       = rd_data;
    assign out_valid = !empty;
  end

endmodule

// File: tb/tb_param_sync_fifo.sv
// Self-checking bench for param_sync_fifo: directed vector table, queue-based
// reference model under random traffic, reset and first-word-fall-through cases.
module tb_param_sync_fifo;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       wr_en, rd_en, clr_err;
  logic [7:0] dout;
  logic       out_valid;
  logic [3:0] fifo_counter;
  logic       empty, full, part_empty, part_full, overflow, underflow;

  logic [7:0] f_din;
  logic       f_wr, f_rd, f_clr;
  logic [7:0] f_out;
  logic       f_valid;
  logic [3:0] f_cnt;
  logic       f_empty, f_full, f_pe, f_pf, f_ov, f_uf;

  int total  = 0;
  int passed = 0;

  // Reference model state
  logic [7:0] q[$];
  logic [7:0] m_out;
  bit         m_valid, m_ov, m_uf;

  typedef struct {
    bit wr; bit rd; bit clr; logic [7:0] din;
    logic [7:0] out; bit valid; int cnt; bit full; bit pf; bit ov; bit uf;
  } vec_t;
  vec_t vecs[$];

  param_sync_fifo u_dut (
    .clk(clk), .rst_n(rst_n), .in(din), .wr_en(wr_en), .rd_en(rd_en),
    .clr_err(clr_err), .out(dout), .out_valid(out_valid),
    .fifo_counter(fifo_counter), .empty(empty), .full(full),
    .part_empty(part_empty), .part_full(part_full),
    .overflow(overflow), .underflow(underflow)
  );

  param_sync_fifo #(.FWFT(1)) u_fw (
    .clk(clk), .rst_n(rst_n), .in(f_din), .wr_en(f_wr), .rd_en(f_rd),
    .clr_err(f_clr), .out(f_out), .out_valid(f_valid),
    .fifo_counter(f_cnt), .empty(f_empty), .full(f_full),
    .part_empty(f_pe), .part_full(f_pf), .overflow(f_ov), .underflow(f_uf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic check_model();
    int n = q.size();
    chk("out", 32'(dout), 32'(m_out));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("fifo_counter", 32'(fifo_counter), 32'(n));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("part_empty", 32'(part_empty), 32'(n <= 2));
    chk("part_full", 32'(part_full), 32'(n >= 6));
    chk("overflow", 32'(overflow), 32'(m_ov));
    chk("underflow", 32'(underflow), 32'(m_uf));
  endtask

  // One clock of stimulus: drive, advance model at the edge, check at negedge
  task automatic step(input bit w, input bit r, input bit c, input logic [7:0] d);
    bit ra, wa;
    wr_en = w; rd_en = r; clr_err = c; din = d;
    @(posedge clk);
    ra = r && (q.size() != 0);
    wa = w && ((q.size() < DEPTH) || ra);
    m_valid = ra;
    if (ra) m_out = q.pop_front();
    if (wa) q.push_back(d);
    if (w && !wa) m_ov = 1'b1; else if (c) m_ov = 1'b0;
    if (r && !ra) m_uf = 1'b1; else if (c) m_uf = 1'b0;
    @(negedge clk);
    check_model();
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
  endtask

  task automatic add(input bit w, r, c, input logic [7:0] d, o, input bit v,
                     input int cnt, input bit fl, pf, ov, uf);
    vec_t e;
    e.wr = w; e.rd = r; e.clr = c; e.din = d; e.out = o; e.valid = v;
    e.cnt = cnt; e.full = fl; e.pf = pf; e.ov = ov; e.uf = uf;
    vecs.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0; din = '0; wr_en = 0; rd_en = 0; clr_err = 0;
    f_din = '0; f_wr = 0; f_rd = 0; f_clr = 0;
    m_out = '0; m_valid = 0; m_ov = 0; m_uf = 0;
    #2;
    check_model();
    chk("fw_reset_valid", 32'(f_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fall-through instance: data visible before any read
    f_wr = 1; f_din = 8'd7;
    @(negedge clk);
    f_wr = 0;
    chk("fw_out", 32'(f_out), 32'd7);
    chk("fw_valid", 32'(f_valid), 32'd1);
    f_rd = 1;
    @(negedge clk);
    f_rd = 0;
    chk("fw_valid_after_pop", 32'(f_valid), 32'd0);
    chk("fw_empty_after_pop", 32'(f_empty), 32'd1);

    // Directed vectors: w r c din | out valid cnt full pf ov uf
    add(1,0,0, 8'd1, 8'd0, 0, 1, 0,0,0,0);
    add(1,0,0, 8'd2, 8'd0, 0, 2, 0,0,0,0);
    add(0,1,0, 8'd0, 8'd1, 1, 1, 0,0,0,0);
    add(0,1,0, 8'd0, 8'd2, 1, 0, 0,0,0,0);
    add(0,0,0, 8'd0, 8'd2, 0, 0, 0,0,0,0);
    for (int i = 1; i <= 8; i++)
      add(1,0,0, 8'(10*i), 8'd2, 0, i, i == 8, i >= 6, 0,0);
    add(1,0,0, 8'd90, 8'd2, 0, 8, 1,1,1,0);
    add(0,0,1, 8'd0,  8'd2, 0, 8, 1,1,0,0);
    add(1,1,0, 8'd90, 8'd10, 1, 8, 1,1,0,0);
    for (int i = 2; i <= 9; i++)
      add(0,1,0, 8'd0, 8'(10*i), 1, 9-i, 0, (9-i) >= 6, 0,0);
    add(0,1,0, 8'd0, 8'd90, 0, 0, 0,0,0,1);
    add(1,1,0, 8'd5, 8'd90, 0, 1, 0,0,0,1);
    add(0,0,1, 8'd0, 8'd90, 0, 1, 0,0,0,0);
    add(0,1,0, 8'd0, 8'd5,  1, 0, 0,0,0,0);

    foreach (vecs[i]) begin
      step(vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].din);
      chk($sformatf("vec%0d_out", i), 32'(dout), 32'(vecs[i].out));
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].valid));
      chk($sformatf("vec%0d_cnt", i), 32'(fifo_counter), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].full));
      chk($sformatf("vec%0d_pf", i), 32'(part_full), 32'(vecs[i].pf));
      chk($sformatf("vec%0d_ov", i), 32'(overflow), 32'(vecs[i].ov));
      chk($sformatf("vec%0d_uf", i), 32'(underflow), 32'(vecs[i].uf));
    end

    // Random traffic with shifting write/read bias against the queue model
    for (int i = 0; i < 400; i++) begin
      int wp, rp;
      case (i / 100)
        0:       begin wp = 75; rp = 30; end
        1:       begin wp = 30; rp = 75; end
        2:       begin wp = 90; rp = 50; end
        default: begin wp = 50; rp = 50; end
      endcase
      step($urandom_range(99) < wp, $urandom_range(99) < rp,
           $urandom_range(99) < 5, 8'($urandom));
    end

    // Mid-operation asynchronous reset discards contents
    for (int i = 0; i < 3; i++) step(1, 0, 0, 8'(100 + i));
    #2 rst_n = 1'b0;
    #1;
    q.delete(); m_out = '0; m_valid = 0; m_ov = 0; m_uf = 0;
    chk("rst_cnt", 32'(fifo_counter), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_part_empty", 32'(part_empty), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_out", 32'(dout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0, 8'd40);
    step(0, 1, 0, 8'd0);
    chk("post_rst_out", 32'(dout), 32'd40);
    chk("post_rst_empty", 32'(empty), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
